// File: rtl/dcache_pkg.sv
// Shared constants, types and line helpers for the L1 data cache.
package dcache_pkg;

    localparam int ADDR_W    = 32;
    localparam int LINE_W    = 256;
    localparam int WORD_W    = 32;
    localparam int NUM_LINES = 32;
    localparam int OFFSET_W  = 5;
    localparam int INDEX_W   = 5;
    localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;

    // Address field positions
    localparam int WSEL_LSB  = 2;
    localparam int WSEL_MSB  = 4;
    localparam int WSEL_W    = WSEL_MSB - WSEL_LSB + 1;
    localparam int IDX_LSB   = OFFSET_W;
    localparam int IDX_MSB   = OFFSET_W + INDEX_W - 1;
    localparam int TAG_LSB   = OFFSET_W + INDEX_W;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        MISS        = 3'd1,
        WB          = 3'd2,
        FILL        = 3'd3,
        REFILL_DONE = 3'd4
    } state_e;

    typedef logic [LINE_W-1:0]  line_t;
    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [INDEX_W-1:0] idx_t;
    typedef logic [WSEL_W-1:0]  wsel_t;
    typedef logic [WORD_W-1:0]  word_t;

    // Extract one 32-bit word from a line
    function automatic word_t line_word(line_t line, wsel_t sel);
        return line[{sel, 5'd0} +: WORD_W];
    endfunction

    // Replace one 32-bit word of a line, leaving the other words intact
    function automatic line_t line_merge(line_t line, wsel_t sel, word_t w);
        line_t r;
        r = line;
        r[{sel, 5'd0} +: WORD_W] = w;
        return r;
    endfunction

    // Line-aligned byte address from tag and index
    function automatic logic [ADDR_W-1:0] line_addr(tag_t t, idx_t i);
        return {t, i, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU word port and memory line port of the data cache, bundled.
interface dcache_if;
    import dcache_pkg::*;

    // CPU MEM-stage side
    logic [ADDR_W-1:0] p1_addr_i;
    logic [WORD_W-1:0] p1_data_i;
    logic              p1_MemRead_i;
    logic              p1_MemWrite_i;
    logic [WORD_W-1:0] p1_data_o;
    logic              p1_stall_o;

    // Data memory side
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;

    // Cache side
    modport slave (
        input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i,
        input  mem_data_i, mem_ack_i,
        output p1_data_o, p1_stall_o,
        output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );

    // CPU + memory side
    modport master (
        output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i,
        output mem_data_i, mem_ack_i,
        input  p1_data_o, p1_stall_o,
        input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o
    );

endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: async read by index, sync write,
// only valid and dirty bits are reset.
module dcache_sram
    import dcache_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  idx_t  idx_i,
    output line_t rd_data_o,
    output tag_t  rd_tag_o,
    output logic  rd_valid_o,
    output logic  rd_dirty_o,
    input  logic  data_we_i,
    input  line_t data_wr_i,
    input  logic  meta_we_i,     // writes tag and marks the line valid
    input  tag_t  tag_wr_i,
    input  logic  dirty_we_i,
    input  logic  dirty_wr_i
);

    line_t                data_q [NUM_LINES];
    tag_t                 tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;

    // Asynchronous read of the addressed line
    always_comb begin
        rd_data_o  = data_q[idx_i];
        rd_tag_o   = tag_q[idx_i];
        rd_valid_o = valid_q[idx_i];
        rd_dirty_o = dirty_q[idx_i];
    end

    // Next state of the valid/dirty bit vectors
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (meta_we_i) begin
            valid_d[idx_i] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
        if (dirty_we_i) begin
            dirty_d[idx_i] = dirty_wr_i;
        end else begin
            dirty_d = dirty_q;
        end
    end

    // Valid/dirty flops, cleared by reset so no stale line can hit
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= {NUM_LINES{1'b0}};
            dirty_q <= {NUM_LINES{1'b0}};
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Data and tag arrays, no reset
    always_ff @(posedge clk_i) begin
        if (data_we_i) begin
            data_q[idx_i] <= data_wr_i;
        end
        if (meta_we_i) begin
            tag_q[idx_i] <= tag_wr_i;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate L1 data cache controller:
// hit logic, word merge and the miss FSM (writeback then fill).
module dcache_controller
    import dcache_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    dcache_if.slave bus
);

    state_e state_q, state_d;

    logic  req_s, wr_s, hit_s, idle_s, hit_ok_s;
    idx_t  idx_s;
    tag_t  tag_s;
    wsel_t wsel_s;
    logic  unused_s;

    line_t rd_data_s;
    tag_t  rd_tag_s;
    logic  rd_valid_s, rd_dirty_s;

    logic  data_we_s, meta_we_s, dirty_we_s, dirty_wr_s;
    line_t data_wr_s;

    dcache_sram u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .idx_i      (idx_s),
        .rd_data_o  (rd_data_s),
        .rd_tag_o   (rd_tag_s),
        .rd_valid_o (rd_valid_s),
        .rd_dirty_o (rd_dirty_s),
        .data_we_i  (data_we_s),
        .data_wr_i  (data_wr_s),
        .meta_we_i  (meta_we_s),
        .tag_wr_i   (tag_s),
        .dirty_we_i (dirty_we_s),
        .dirty_wr_i (dirty_wr_s)
    );

    // Request decode and hit detection
    always_comb begin
        req_s    = bus.p1_MemRead_i | bus.p1_MemWrite_i;
        wr_s     = bus.p1_MemWrite_i;   // read+write together counts as a write
        idx_s    = bus.p1_addr_i[IDX_MSB:IDX_LSB];
        tag_s    = bus.p1_addr_i[ADDR_W-1:TAG_LSB];
        wsel_s   = bus.p1_addr_i[WSEL_MSB:WSEL_LSB];
        unused_s = ^bus.p1_addr_i[WSEL_LSB-1:0];
        hit_s    = rd_valid_s & (rd_tag_s == tag_s);
        idle_s   = (state_q == IDLE);
        hit_ok_s = req_s & hit_s & idle_s;
    end

    // CPU-facing outputs; held quiet while reset is asserted so the stall
    // releases immediately even if the CPU keeps its request up
    always_comb begin
        if (rst_i & hit_ok_s) begin
            bus.p1_stall_o = 1'b0;
            bus.p1_data_o  = line_word(rd_data_s, wsel_s);
        end else if (rst_i & req_s) begin
            bus.p1_stall_o = 1'b1;
            bus.p1_data_o  = {WORD_W{1'b0}};
        end else begin
            bus.p1_stall_o = 1'b0;
            bus.p1_data_o  = {WORD_W{1'b0}};
        end
    end

    // Array write controls: store hit merge, fill install, writeback clean
    always_comb begin
        data_we_s  = 1'b0;
        data_wr_s  = rd_data_s;
        meta_we_s  = 1'b0;
        dirty_we_s = 1'b0;
        dirty_wr_s = 1'b0;
        if (hit_ok_s & wr_s) begin
            data_we_s  = 1'b1;
            data_wr_s  = line_merge(rd_data_s, wsel_s, bus.p1_data_i);
            dirty_we_s = 1'b1;
            dirty_wr_s = 1'b1;
        end else if ((state_q == FILL) && bus.mem_ack_i) begin
            data_we_s  = 1'b1;
            data_wr_s  = bus.mem_data_i;
            meta_we_s  = 1'b1;
            dirty_we_s = 1'b1;
            dirty_wr_s = 1'b0;
        end else if ((state_q == WB) && bus.mem_ack_i) begin
            dirty_we_s = 1'b1;
            dirty_wr_s = 1'b0;
        end else begin
            data_we_s  = 1'b0;
        end
    end

    // FSM state register; reset aborts any miss in flight
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_s & ~hit_s) begin
                    state_d = MISS;
                end else begin
                    state_d = IDLE;
                end
            end
            MISS: begin
                if (rd_valid_s & rd_dirty_s) begin
                    state_d = WB;
                end else begin
                    state_d = FILL;
                end
            end
            WB: begin
                if (bus.mem_ack_i) begin
                    state_d = FILL;
                end else begin
                    state_d = WB;
                end
            end
            FILL: begin
                if (bus.mem_ack_i) begin
                    state_d = REFILL_DONE;
                end else begin
                    state_d = FILL;
                end
            end
            REFILL_DONE: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // FSM outputs: memory request decoded from the current state
    always_comb begin
        bus.mem_enable_o = 1'b0;
        bus.mem_write_o  = 1'b0;
        bus.mem_addr_o   = {ADDR_W{1'b0}};
        bus.mem_data_o   = {LINE_W{1'b0}};
        case (state_q)
            WB: begin
                bus.mem_enable_o = 1'b1;
                bus.mem_write_o  = 1'b1;
                bus.mem_addr_o   = line_addr(rd_tag_s, idx_s);
                bus.mem_data_o   = rd_data_s;
            end
            FILL: begin
                bus.mem_enable_o = 1'b1;
                bus.mem_write_o  = 1'b0;
                bus.mem_addr_o   = line_addr(tag_s, idx_s);
            end
            default: begin
                bus.mem_enable_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed scoreboard bench for dcache_controller: stimulus pushes
// expected loads and memory requests; monitors pop and compare.
`timescale 1ns/1ps
module tb_dcache_controller;
    import dcache_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dcache_if bus ();

    dcache_controller dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  wsel;
        logic [31:0] word;
    } mem_exp_t;

    mem_exp_t    mem_q [$];
    logic [31:0] rd_q [$];
    mem_exp_t    mem_e;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Memory content is a fixed pattern: word w of line A = {A[15:0], w}
    function automatic logic [255:0] fill_line(input logic [31:0] a);
        logic [255:0] l;
        logic [2:0]   w3;
        for (int w = 0; w < 8; w++) begin
            w3 = w[2:0];
            l[w*32 +: 32] = {a[15:0], 13'd0, w3};
        end
        return l;
    endfunction

    task automatic mem_push(input logic wr, input logic [31:0] addr,
                            input logic [2:0] wsel, input logic [31:0] word);
        mem_exp_t e;
        e.wr = wr; e.addr = addr; e.wsel = wsel; e.word = word;
        mem_q.push_back(e);
    endtask

    // Memory model: sample enable on negedge, ack 8 negedges later
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_cur;
    int          stray_req  = 0;
    int          stray_seen = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_busy       <= 1'b0;
            mem_cnt        <= 0;
            bus.mem_ack_i  <= 1'b0;
            bus.mem_data_i <= {256{1'b0}};
        end else if (bus.mem_ack_i) begin
            bus.mem_ack_i <= 1'b0;
            mem_busy      <= 1'b0;
        end else if (mem_busy) begin
            if (mem_cnt == 7) begin
                bus.mem_ack_i  <= 1'b1;
                bus.mem_data_i <= fill_line(mem_cur);
            end
            mem_cnt <= mem_cnt + 1;
        end else if (bus.mem_enable_o) begin
            mem_busy <= 1'b1;
            mem_cnt  <= 0;
            mem_cur  <= bus.mem_addr_o;
            if (mem_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mem_unexpected: got request addr 0x%08h write %b expected none",
                         bus.mem_addr_o, bus.mem_write_o);
            end else begin
                mem_e = mem_q.pop_front();
                chk_bit("mem_write", bus.mem_write_o, mem_e.wr);
                chk32("mem_addr", bus.mem_addr_o, mem_e.addr);
                if (mem_e.wr) begin
                    chk32("wb_word", bus.mem_data_o[{mem_e.wsel, 5'd0} +: 32], mem_e.word);
                end
            end
        end else if (stray_req != stray_seen) begin
            stray_seen     <= stray_req;
            bus.mem_ack_i  <= 1'b1;
            bus.mem_data_i <= {256{1'b1}};
        end
    end

    // Load monitor: every completed read is compared with the scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.p1_MemRead_i && !bus.p1_MemWrite_i && !bus.p1_stall_o) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL load_unexpected: got 0x%08h expected no load", bus.p1_data_o);
            end else begin
                chk32("load_data", bus.p1_data_o, rd_q.pop_front());
            end
        end
    end

    // One CPU access; counts stalled negedges and checks it against exp_stall
    task automatic cpu_access(input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int exp_stall);
        int n;
        @(posedge clk); #1;
        bus.p1_addr_i     = addr;
        bus.p1_data_i     = wdata;
        bus.p1_MemRead_i  = ~wr;
        bus.p1_MemWrite_i = wr;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (exp_stall == 0) chk_bit("hit_no_mem_enable", bus.mem_enable_o, 1'b0);
            if (!bus.p1_stall_o) break;
            n++;
        end
        chk_int("stall_cycles", n, exp_stall);
        @(posedge clk); #1;
        bus.p1_MemRead_i  = 1'b0;
        bus.p1_MemWrite_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        bus.p1_addr_i     = 32'd0;
        bus.p1_data_i     = 32'd0;
        bus.p1_MemRead_i  = 1'b0;
        bus.p1_MemWrite_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_bit("rst_stall",  bus.p1_stall_o,   1'b0);
        chk_bit("rst_enable", bus.mem_enable_o, 1'b0);
        chk_bit("rst_write",  bus.mem_write_o,  1'b0);
        chk32("rst_mem_addr", bus.mem_addr_o,   32'd0);
        chk32("rst_data_o",   bus.p1_data_o,    32'd0);
        #2 rst_n = 1'b1;

        // Cold read: one clean fill, word 0 of line 0x400
        mem_push(1'b0, 32'h0000_0400, 3'd0, 32'd0);
        rd_q.push_back(32'h0400_0000);
        cpu_access(1'b0, 32'h0000_0400, 32'd0, 12);

        // Read hit, word 1, zero stall
        rd_q.push_back(32'h0400_0001);
        cpu_access(1'b0, 32'h0000_0404, 32'd0, 0);

        // Idle: no request gives zero data and no stall
        @(negedge clk);
        chk32("idle_data_o", bus.p1_data_o, 32'd0);
        chk_bit("idle_stall", bus.p1_stall_o, 1'b0);

        // Write hit then read back; neighbour word untouched
        cpu_access(1'b1, 32'h0000_0408, 32'hDEAD_BEEF, 0);
        rd_q.push_back(32'hDEAD_BEEF);
        cpu_access(1'b0, 32'h0000_0408, 32'd0, 0);
        rd_q.push_back(32'h0400_0003);
        cpu_access(1'b0, 32'h0000_040C, 32'd0, 0);

        // Stray ack while idle must not disturb the line
        stray_req++;
        repeat (3) @(posedge clk);
        rd_q.push_back(32'h0400_0001);
        cpu_access(1'b0, 32'h0000_0404, 32'd0, 0);

        // Conflict miss on dirty line: writeback 0x400 then fill 0x800
        mem_push(1'b1, 32'h0000_0400, 3'd2, 32'hDEAD_BEEF);
        mem_push(1'b0, 32'h0000_0800, 3'd0, 32'd0);
        rd_q.push_back(32'h0800_0000);
        cpu_access(1'b0, 32'h0000_0800, 32'd0, 22);

        // Freshly filled line is clean: evicting it needs only a fill
        mem_push(1'b0, 32'h0000_0400, 3'd0, 32'd0);
        rd_q.push_back(32'h0400_0001);
        cpu_access(1'b0, 32'h0000_0404, 32'd0, 12);

        // Write miss to clean line: fill 0xC20, then word 1 merged
        mem_push(1'b0, 32'h0000_0C20, 3'd0, 32'd0);
        cpu_access(1'b1, 32'h0000_0C24, 32'h1234_5678, 12);
        rd_q.push_back(32'h1234_5678);
        cpu_access(1'b0, 32'h0000_0C24, 32'd0, 0);
        rd_q.push_back(32'h0C20_0000);
        cpu_access(1'b0, 32'h0000_0C20, 32'd0, 0);

        // Evict the written line: writeback carries the merged word
        mem_push(1'b1, 32'h0000_0C20, 3'd1, 32'h1234_5678);
        mem_push(1'b0, 32'h0000_1020, 3'd0, 32'd0);
        rd_q.push_back(32'h1020_0001);
        cpu_access(1'b0, 32'h0000_1024, 32'd0, 22);
        cpu_access(1'b1, 32'h0000_1024, 32'hCAFE_F00D, 0);

        // Reset during fill wait
        mem_push(1'b0, 32'h0000_1040, 3'd0, 32'd0);
        @(posedge clk); #1;
        bus.p1_addr_i    = 32'h0000_1040;
        bus.p1_MemRead_i = 1'b1;
        waited = 0;
        while (!bus.mem_enable_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk_bit("fill_started", bus.mem_enable_o, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_bit("midrst_enable", bus.mem_enable_o, 1'b0);
        chk_bit("midrst_stall",  bus.p1_stall_o,   1'b0);
        chk32("midrst_data_o",   bus.p1_data_o,    32'd0);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk_bit("postrst_miss", bus.p1_stall_o, 1'b1);
        mem_push(1'b0, 32'h0000_1040, 3'd0, 32'd0);
        rd_q.push_back(32'h1040_0000);
        waited = 0;
        @(negedge clk);
        while (bus.p1_stall_o && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk_bit("postrst_done", bus.p1_stall_o, 1'b0);
        @(posedge clk); #1;
        bus.p1_MemRead_i = 1'b0;

        // Dirty line before reset is now invalid and clean: fill only
        mem_push(1'b0, 32'h0000_1020, 3'd0, 32'd0);
        rd_q.push_back(32'h1020_0001);
        cpu_access(1'b0, 32'h0000_1024, 32'd0, 12);

        repeat (4) @(posedge clk);
        chk_int("mem_q_drained", mem_q.size(), 0);
        chk_int("rd_q_drained",  rd_q.size(),  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache.
- Sits between the CPU MEM stage (32-bit word port) and the 256-bit line-based data memory.
- Serves hits with no stall. On a miss it stalls the pipeline, writes back a dirty victim line, fetches the new line over the memory enable/write/ack handshake, then completes the access.

Parameters:
- NUM_LINES, 32, number of cache lines; index width = log2(NUM_LINES) = 5
- LINE_W, 256, line width in bits (32 bytes, 8 words); matches memory data width
- ADDR_W, 32, byte address width; tag = ADDR_W-5-5 = 22 bits

Ports:
- clk_i  in  1  clock; all cache state updates on posedge
- rst_i  in  1  asynchronous, active-low reset
- p1_addr_i  in  32  CPU byte address; offset [4:0], word select [4:2], index [9:5], tag [31:10]
- p1_data_i  in  32  CPU write data
- p1_MemRead_i  in  1  load request
- p1_MemWrite_i  in  1  store request
- p1_data_o  out  32  load data; valid when request active and p1_stall_o=0
- p1_stall_o  out  1  high while the current request is not yet satisfied
- mem_addr_o  out  32  line-aligned byte address (low 5 bits zero)
- mem_data_o  out  256  victim line for writeback
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1 = writeback, 0 = fill
- mem_data_i  in  256  fill data; valid in the cycle mem_ack_i is sampled high
- mem_ack_i  in  1  one-cycle completion pulse from memory

Behaviour:
- Per line storage: valid bit, dirty bit, 22-bit tag, 256-bit data.
- Reset: all valid and dirty bits cleared. FSM to IDLE. mem_enable_o=0, mem_write_o=0, p1_stall_o=0, p1_data_o=0, mem_addr_o=0. Data and tag arrays are not cleared.
- req = p1_MemRead_i | p1_MemWrite_i. If both are high, the access is treated as a write.
- hit = valid[idx] & (tag[idx]==p1_addr_i[31:10]).
- p1_stall_o = req & ~(hit & state==IDLE), combinational.
- Read hit: p1_data_o = word p1_addr_i[4:2] of line, combinational, same cycle. Zero stall.
- Write hit: at posedge, the selected 32-bit word is replaced and dirty[idx] is set. Other 7 words are unchanged.
- No request: p1_data_o = 0. No state change.
- The CPU holds addr, data and read/write request stable while p1_stall_o=1.
- FSM states:
  - IDLE: on req & ~hit, go to MISS.
  - MISS: if valid & dirty, go to WB and set mem_write_o=1. Otherwise go to FILL and set mem_write_o=0.
  - WB: mem_enable_o=1, mem_addr_o={old_tag,idx,5'b0}, mem_data_o=line[idx]. On posedge with mem_ack_i=1: clear dirty[idx] and go to FILL.
  - FILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={p1_tag,idx,5'b0}. On posedge with mem_ack_i=1: write mem_data_i into line, set tag, valid=1, dirty=0, go to REFILL_DONE.
  - REFILL_DONE: mem_enable_o=0, go to IDLE. The access now hits and is completed by the normal hit path; a store sets dirty there.
- mem_enable_o is high only in WB and FILL. It drops combinationally in the state after ack, so memory sees enable low before it returns to its idle state.
- In WB→FILL, enable stays high. The address and mem_write_o change at the posedge, before the next memory negedge sample.
- Memory ack arrives 8 negedges after enable is first sampled.
- Miss latency, clean victim: 1 (MISS) + fill handshake + 1 (REFILL_DONE) + hit cycle.
- Miss latency, dirty victim: one additional full handshake.
- mem_ack_i outside WB/FILL is ignored.
- Reset mid-miss: FSM returns to IDLE and enable drops immediately. A partially fetched line is never marked valid.

Decomposition:
- Shared package dcache_pkg holds:
  - Constants: OFFSET_W=5, INDEX_W=5, TAG_W=22, WORD_SEL range.
  - FSM state encoding: IDLE, MISS, WB, FILL, REFILL_DONE (3 bits).
- Sub-module dcache_sram holds tag/valid/dirty/data arrays.
  - Async read by index.
  - Sync write with enable.
  - Async reset of valid/dirty only.
- Top level holds the FSM, hit logic and word merge.

Test Plan:
- Cold read 0x0000_0400 after reset → stall=1. One fill with mem_addr_o=0x400, mem_write_o=0. Then p1_data_o = word 0 of the fill line, stall drops. No writeback issued.
- Read 0x404 immediately after → hit; p1_data_o = word 1 in the same cycle, stall=0, mem_enable_o stays 0.
- Write 0xDEADBEEF to 0x408 (hit) → no memory traffic. Re-read 0x408 returns 0xDEADBEEF. dirty[0]=1.
- Read 0x0000_0800 (same index 0, new tag) → writeback first: mem_addr_o=0x400, mem_write_o=1, mem_data_o word 2 = 0xDEADBEEF. Then fill at 0x800. Exactly two handshakes.
- Write miss to clean line 0x0000_0C24 → fill at 0xC20, then word 1 merged. Line dirty. Read 0xC24 returns the written value.
- Assert rst_i=0 during FILL wait → mem_enable_o=0 and p1_stall_o=0 asynchronously. After reset, read of the same address misses again (valid=0).
